seg_scan_decoder: RTL and testbench

Receive-side counterpart of the vending machine's multiplexed 7-segment display driver. Samples the 8-digit scan outputs (digit select plus segment lines) and reconstructs the displayed hex value for every digit. Publishes a complete frame once all eight digits have been observed, and flags malformed scan activity. Used in benches and on-chip self-check to read the display back as numbers instead of raw segment bits.

---
 rtl/seg_scan_pkg.sv | 55 +++++
 rtl/seg7_pattern_decode.sv | 34 +++
 rtl/seg_scan_decoder.sv | 165 ++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared definitions for 7-segment scan readback: FSM states, segment bit order,
// the hex glyph set and the decoder result record.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        COLLECT = 2'd1,
        PUBLISH = 2'd2
    } state_e;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] M_A = 7'd1 << SEG_A;
    localparam logic [6:0] M_B = 7'd1 << SEG_B;
    localparam logic [6:0] M_C = 7'd1 << SEG_C;
    localparam logic [6:0] M_D = 7'd1 << SEG_D;
    localparam logic [6:0] M_E = 7'd1 << SEG_E;
    localparam logic [6:0] M_F = 7'd1 << SEG_F;
    localparam logic [6:0] M_G = 7'd1 << SEG_G;

    localparam logic [6:0] PAT_0 = M_A | M_B | M_C | M_D | M_E | M_F;
    localparam logic [6:0] PAT_1 = M_B | M_C;
    localparam logic [6:0] PAT_2 = M_A | M_B | M_D | M_E | M_G;
    localparam logic [6:0] PAT_3 = M_A | M_B | M_C | M_D | M_G;
    localparam logic [6:0] PAT_4 = M_B | M_C | M_F | M_G;
    localparam logic [6:0] PAT_5 = M_A | M_C | M_D | M_F | M_G;
    localparam logic [6:0] PAT_6 = M_A | M_C | M_D | M_E | M_F | M_G;
    localparam logic [6:0] PAT_7 = M_A | M_B | M_C;
    localparam logic [6:0] PAT_8 = M_A | M_B | M_C | M_D | M_E | M_F | M_G;
    localparam logic [6:0] PAT_9 = M_A | M_B | M_C | M_D | M_F | M_G;
    localparam logic [6:0] PAT_A = M_A | M_B | M_C | M_E | M_F | M_G;
    localparam logic [6:0] PAT_B = M_C | M_D | M_E | M_F | M_G;
    localparam logic [6:0] PAT_C = M_A | M_D | M_E | M_F;
    localparam logic [6:0] PAT_D = M_B | M_C | M_D | M_E | M_G;
    localparam logic [6:0] PAT_E = M_A | M_D | M_E | M_F | M_G;
    localparam logic [6:0] PAT_F = M_A | M_E | M_F | M_G;
    localparam logic [6:0] BLANK_PAT = 7'h00;

    typedef struct packed {
        logic       valid;
        logic       blank;
        logic [3:0] nibble;
    } seg_dec_t;

    function automatic logic is_onehot8(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational glyph decoder: active-high segment pattern to hex nibble,
// with a blank flag for all-off and valid cleared for anything unrecognised.
module seg7_pattern_decode
    import seg_scan_pkg::*;
(
    input  logic [6:0] pattern,
    output seg_dec_t   dec
);

    always_comb begin
        dec = '{valid: 1'b1, blank: 1'b0, nibble: 4'h0};
        case (pattern)
            PAT_0:     dec.nibble = 4'h0;
            PAT_1:     dec.nibble = 4'h1;
            PAT_2:     dec.nibble = 4'h2;
            PAT_3:     dec.nibble = 4'h3;
            PAT_4:     dec.nibble = 4'h4;
            PAT_5:     dec.nibble = 4'h5;
            PAT_6:     dec.nibble = 4'h6;
            PAT_7:     dec.nibble = 4'h7;
            PAT_8:     dec.nibble = 4'h8;
            PAT_9:     dec.nibble = 4'h9;
            PAT_A:     dec.nibble = 4'hA;
            PAT_B:     dec.nibble = 4'hB;
            PAT_C:     dec.nibble = 4'hC;
            PAT_D:     dec.nibble = 4'hD;
            PAT_E:     dec.nibble = 4'hE;
            PAT_F:     dec.nibble = 4'hF;
            BLANK_PAT: dec.blank  = 1'b1;
            default:   dec.valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Reads a multiplexed 8-digit 7-segment scan back into hex values, publishing a
// full frame once every digit has been captured after syncing on digit 0.
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter bit DIGIT_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW   = 1'b1,
    parameter int STABLE_CYCLES    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  DIGIT,
    input  logic [6:0]  SEG,
    input  logic        err_clr,
    output logic [31:0] frame_value,
    output logic [7:0]  frame_blank,
    output logic        frame_valid,
    output logic [15:0] frame_count,
    output logic        err_pattern,
    output logic        err_select
);

    localparam logic [3:0] STABLE_N = 4'(STABLE_CYCLES);

    function automatic logic [3:0] sat_inc(input logic [3:0] c);
        return (c >= STABLE_N) ? STABLE_N : c + 4'd1;
    endfunction

    logic [7:0]  sel_p0_d, sel_p0_q;
    logic [6:0]  seg_p0_d, seg_p0_q;
    logic [14:0] pair_p1_q;
    logic [3:0]  cnt_d, cnt_q;
    logic        pair_chg, cap_vld_p1;
    seg_dec_t    dec_p1;
    logic        sel_onehot;
    logic [2:0]  sel_idx;
    logic [7:0]  sel_bit;
    logic        wr_en, do_write, pat_err, sel_err;

    state_e      state_d, state_q;
    logic [7:0]  seen_d, seen_q;
    logic [31:0] shadow_d, shadow_q;
    logic [7:0]  sblank_d, sblank_q;
    logic [31:0] frame_value_d, frame_value_q;
    logic [7:0]  frame_blank_d, frame_blank_q;
    logic        frame_valid_d, frame_valid_q;
    logic [15:0] frame_count_d, frame_count_q;
    logic        err_pattern_d, err_pattern_q;
    logic        err_select_d, err_select_q;

    // Stage p0: polarity-normalised input register
    always_comb begin
        sel_p0_d = DIGIT_ACTIVE_LOW ? ~DIGIT : DIGIT;
        seg_p0_d = SEG_ACTIVE_LOW ? ~SEG : SEG;
    end

    always_ff @(posedge clk) begin
        sel_p0_q  <= sel_p0_d;
        seg_p0_q  <= seg_p0_d;
        pair_p1_q <= {sel_p0_q, seg_p0_q};
    end

    seg7_pattern_decode u_decode (
        .pattern (seg_p0_q),
        .dec     (dec_p1)
    );

    // Stage p1: stability counting and single-shot capture classification
    always_comb begin
        pair_chg   = ({sel_p0_q, seg_p0_q} != pair_p1_q);
        cnt_d      = pair_chg ? 4'd1 : sat_inc(cnt_q);
        cap_vld_p1 = (cnt_d == STABLE_N) && (pair_chg || (cnt_q != STABLE_N));
        sel_onehot = is_onehot8(sel_p0_q);
        sel_idx    = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (sel_p0_q[k]) sel_idx = 3'(k);
        end
        sel_bit  = 8'd1 << sel_idx;
        wr_en    = cap_vld_p1 && sel_onehot && dec_p1.valid;
        pat_err  = cap_vld_p1 && sel_onehot && !dec_p1.valid;
        sel_err  = cap_vld_p1 && (sel_p0_q != 8'd0) && !sel_onehot;
        do_write = wr_en && ((state_q != SYNC) || (sel_idx == 3'd0));
    end

    always_comb begin
        state_d       = state_q;
        seen_d        = seen_q;
        shadow_d      = shadow_q;
        sblank_d      = sblank_q;
        frame_value_d = frame_value_q;
        frame_blank_d = frame_blank_q;
        frame_valid_d = 1'b0;
        frame_count_d = frame_count_q;
        err_pattern_d = (err_pattern_q && !err_clr) || pat_err;
        err_select_d  = (err_select_q && !err_clr) || sel_err;

        if (do_write) begin
            shadow_d[4*sel_idx +: 4] = dec_p1.nibble;
            sblank_d[sel_idx]        = dec_p1.blank;
        end

        case (state_q)
            SYNC: begin
                if (do_write) begin
                    seen_d  = 8'h01;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (do_write) begin
                    seen_d = seen_q | sel_bit;
                    if (seen_d == 8'hFF) begin
                        state_d       = PUBLISH;
                        frame_value_d = shadow_d;
                        frame_blank_d = sblank_d;
                        frame_valid_d = 1'b1;
                        frame_count_d = frame_count_q + 16'd1;
                    end
                end
            end
            PUBLISH: begin
                // A capture landing here belongs to the next frame
                seen_d  = do_write ? sel_bit : 8'h00;
                state_d = COLLECT;
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= SYNC;
            cnt_q         <= '0;
            seen_q        <= '0;
            shadow_q      <= '0;
            sblank_q      <= '0;
            frame_value_q <= '0;
            frame_blank_q <= '0;
            frame_valid_q <= 1'b0;
            frame_count_q <= '0;
            err_pattern_q <= 1'b0;
            err_select_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            seen_q        <= seen_d;
            shadow_q      <= shadow_d;
            sblank_q      <= sblank_d;
            frame_value_q <= frame_value_d;
            frame_blank_q <= frame_blank_d;
            frame_valid_q <= frame_valid_d;
            frame_count_q <= frame_count_d;
            err_pattern_q <= err_pattern_d;
            err_select_q  <= err_select_d;
        end
    end

    assign frame_value = frame_value_q;
    assign frame_blank = frame_blank_q;
    assign frame_valid = frame_valid_q;
    assign frame_count = frame_count_q;
    assign err_pattern = err_pattern_q;
    assign err_select  = err_select_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: drives active-low scans and compares against a
// frame-level model of held pin pairs, captures and frame assembly.
module tb_seg_scan_decoder;

    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  DIGIT;
    logic [6:0]  SEG;
    logic        err_clr;
    logic [31:0] frame_value;
    logic [7:0]  frame_blank;
    logic        frame_valid;
    logic [15:0] frame_count;
    logic        err_pattern;
    logic        err_select;

    always #5 clk = ~clk;

    seg_scan_decoder #(
        .DIGIT_ACTIVE_LOW (1'b1),
        .SEG_ACTIVE_LOW   (1'b1),
        .STABLE_CYCLES    (STABLE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .DIGIT       (DIGIT),
        .SEG         (SEG),
        .err_clr     (err_clr),
        .frame_value (frame_value),
        .frame_blank (frame_blank),
        .frame_valid (frame_valid),
        .frame_count (frame_count),
        .err_pattern (err_pattern),
        .err_select  (err_select)
    );

    logic [6:0] pat_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model state
    bit          m_sync;
    logic [31:0] m_shadow, m_value;
    logic [7:0]  m_sblank, m_seen, m_blank;
    logic [15:0] m_count;
    bit          m_errp, m_errs;
    int          m_pulses, m_pub_cyc, m_run;
    logic [14:0] m_prev = 15'h7FFF;

    int o_pulses, o_pub_cyc;

    function automatic bit lookup(input logic [6:0] s, output logic [3:0] v, output bit b);
        v = 4'h0;
        b = 1'b0;
        if (s == 7'h00) begin
            b = 1'b1;
            return 1'b1;
        end
        for (int i = 0; i < 16; i++) begin
            if (pat_tab[i] == s) begin
                v = 4'(i);
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_sync = 1'b1; m_shadow = '0; m_sblank = '0; m_seen = '0;
        m_value = '0; m_blank = '0; m_count = '0; m_errp = 1'b0; m_errs = 1'b0;
    endtask

    task automatic model_capture(input logic [7:0] sel, input logic [6:0] seg);
        logic [3:0] v;
        bit b;
        int k;
        if (sel == 8'd0) return;
        if ($countones(sel) != 1) begin m_errs = 1'b1; return; end
        k = 0;
        for (int i = 0; i < 8; i++) if (sel[i]) k = i;
        if (!lookup(seg, v, b)) begin m_errp = 1'b1; return; end
        if (m_sync && k != 0) return;
        m_sync = 1'b0;
        m_shadow[4*k +: 4] = v;
        m_sblank[k] = b;
        m_seen[k] = 1'b1;
        if (m_seen == 8'hFF) begin
            m_value = m_shadow; m_blank = m_sblank; m_count++;
            m_pulses++; m_seen = '0; m_pub_cyc = cyc + 1;
        end
    endtask

    task automatic step(input logic [7:0] sel, input logic [6:0] seg, input bit clr);
        DIGIT = ~sel;
        SEG = ~seg;
        err_clr = clr;
        @(posedge clk);
        cyc++;
        if (clr) begin m_errp = 1'b0; m_errs = 1'b0; end
        if ({sel, seg} == m_prev) m_run++;
        else begin m_prev = {sel, seg}; m_run = 1; end
        if (m_run == STABLE && !rst) model_capture(sel, seg);
        @(negedge clk);
        if (frame_valid) begin o_pulses++; o_pub_cyc = cyc; end
    endtask

    task automatic hold(input logic [7:0] sel, input logic [6:0] seg, input int n);
        repeat (n) step(sel, seg, 1'b0);
    endtask

    task automatic idle(input int n);
        hold(8'd0, 7'd0, n);
    endtask

    task automatic scan(input logic [31:0] vals, input logic [7:0] blanks, input int len, input int gap);
        for (int k = 0; k < 8; k++) begin
            hold(8'd1 << k, blanks[k] ? 7'h00 : pat_tab[vals[4*k +: 4]], len);
            idle(gap);
        end
    endtask

    task automatic clear_obs();
        o_pulses = 0; m_pulses = 0; o_pub_cyc = -1; m_pub_cyc = -2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (3) step(8'd0, 7'd0, 1'b0);
        checks++; if (frame_value !== 32'd0) begin errors++; $display("FAIL reset_value: got %h want 0", frame_value); end
        checks++; if (frame_blank !== 8'd0) begin errors++; $display("FAIL reset_blank: got %h want 0", frame_blank); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", frame_valid); end
        checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", frame_count); end
        checks++; if (err_pattern !== 1'b0) begin errors++; $display("FAIL reset_errp: got %b want 0", err_pattern); end
        checks++; if (err_select !== 1'b0) begin errors++; $display("FAIL reset_errs: got %b want 0", err_select); end
        rst = 1'b0;
    endtask

    task automatic test_basic_frame();
        clear_obs();
        scan(32'h87654321, 8'h00, 8, 2);
        idle(8);
        checks++; if (o_pulses != 1) begin errors++; $display("FAIL basic_pulses: got %0d want 1", o_pulses); end
        checks++; if (frame_value !== 32'h87654321) begin errors++; $display("FAIL basic_value: got %h want 87654321", frame_value); end
        checks++; if (frame_blank !== 8'h00) begin errors++; $display("FAIL basic_blank: got %h want 00", frame_blank); end
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL basic_count: got %0d want 1", frame_count); end
        checks++; if (o_pub_cyc != m_pub_cyc) begin errors++; $display("FAIL basic_latency: got cycle %0d want %0d", o_pub_cyc, m_pub_cyc); end
        checks++; if ({err_pattern, err_select} !== 2'b00) begin errors++; $display("FAIL basic_errs: got %b want 00", {err_pattern, err_select}); end
    endtask

    task automatic test_start_mid();
        logic [31:0] vals;
        rst = 1'b1;
        model_reset();
        repeat (2) step(8'd0, 7'd0, 1'b0);
        rst = 1'b0;
        clear_obs();
        for (int k = 3; k < 8; k++) begin
            hold(8'd1 << k, pat_tab[k], 6);
            idle(1);
        end
        idle(6);
        checks++; if (o_pulses != 0) begin errors++; $display("FAIL start_mid_early: got %0d pulses want 0", o_pulses); end
        vals = $urandom;
        scan(vals, 8'h00, 6, 1);
        idle(8);
        checks++; if (o_pulses != 1) begin errors++; $display("FAIL start_mid_pulses: got %0d want 1", o_pulses); end
        checks++; if (frame_value !== vals) begin errors++; $display("FAIL start_mid_value: got %h want %h", frame_value, vals); end
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL start_mid_count: got %0d want 1", frame_count); end
    endtask

    task automatic test_pattern_err();
        logic [31:0] vals;
        vals = $urandom;
        clear_obs();
        for (int k = 0; k < 8; k++) begin
            hold(8'd1 << k, (k == 2) ? 7'h40 : pat_tab[vals[4*k +: 4]], 8);
            idle(2);
        end
        idle(8);
        checks++; if (err_pattern !== 1'b1) begin errors++; $display("FAIL pat_err_set: got %b want 1", err_pattern); end
        checks++; if (o_pulses != 0) begin errors++; $display("FAIL pat_err_nopub: got %0d pulses want 0", o_pulses); end
        step(8'd0, 7'd0, 1'b1);
        idle(3);
        checks++; if (err_pattern !== 1'b0) begin errors++; $display("FAIL pat_err_clr: got %b want 0", err_pattern); end
        checks++; if (err_select !== 1'b0) begin errors++; $display("FAIL pat_err_sel: got %b want 0", err_select); end
        scan(vals, 8'h00, 8, 2);
        idle(8);
        checks++; if (o_pulses != m_pulses) begin errors++; $display("FAIL pat_err_pulses: got %0d want %0d", o_pulses, m_pulses); end
        checks++; if (frame_value !== m_value) begin errors++; $display("FAIL pat_err_value: got %h want %h", frame_value, m_value); end
    endtask

    task automatic test_select_err();
        clear_obs();
        hold(8'h12, pat_tab[5], 6);
        idle(6);
        checks++; if (err_select !== 1'b1) begin errors++; $display("FAIL sel_err_set: got %b want 1", err_select); end
        checks++; if (err_pattern !== 1'b0) begin errors++; $display("FAIL sel_err_pat: got %b want 0", err_pattern); end
        checks++; if (o_pulses != 0) begin errors++; $display("FAIL sel_err_nopub: got %0d pulses want 0", o_pulses); end
        step(8'd0, 7'd0, 1'b1);
        idle(2);
        checks++; if (err_select !== 1'b0) begin errors++; $display("FAIL sel_err_clr: got %b want 0", err_select); end
    endtask

    task automatic test_glitch_blank();
        logic [31:0] vals, expv;
        rst = 1'b1;
        model_reset();
        repeat (2) step(8'd0, 7'd0, 1'b0);
        rst = 1'b0;
        clear_obs();
        vals = $urandom;
        for (int k = 0; k < 5; k++) begin
            hold(8'd1 << k, pat_tab[vals[4*k +: 4]], 6);
            idle(2);
        end
        hold(8'd1 << 3, pat_tab[~vals[15:12]], 2);
        idle(2);
        hold(8'd1 << 1, pat_tab[~vals[7:4]], STABLE - 1);
        idle(2);
        hold(8'd1 << 5, 7'h00, 6);
        idle(2);
        for (int k = 6; k < 8; k++) begin
            hold(8'd1 << k, pat_tab[vals[4*k +: 4]], 6);
            idle(2);
        end
        idle(8);
        expv = vals;
        expv[23:20] = 4'h0;
        checks++; if (o_pulses != 1) begin errors++; $display("FAIL glitch_pulses: got %0d want 1", o_pulses); end
        checks++; if (frame_value !== expv) begin errors++; $display("FAIL glitch_value: got %h want %h", frame_value, expv); end
        checks++; if (frame_blank !== 8'h20) begin errors++; $display("FAIL glitch_blank: got %h want 20", frame_blank); end
        checks++; if ({err_pattern, err_select} !== 2'b00) begin errors++; $display("FAIL glitch_errs: got %b want 00", {err_pattern, err_select}); end
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL glitch_count: got %0d want 1", frame_count); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        clear_obs();
        for (int i = 0; i < 3; i++) begin
            v = $urandom;
            scan(v, 8'h00, 5, 0);
        end
        idle(8);
        checks++; if (o_pulses != 3) begin errors++; $display("FAIL b2b_pulses: got %0d want 3", o_pulses); end
        checks++; if (frame_value !== v) begin errors++; $display("FAIL b2b_value: got %h want %h", frame_value, v); end
        checks++; if (frame_count !== 16'd4) begin errors++; $display("FAIL b2b_count: got %0d want 4", frame_count); end
    endtask

    task automatic test_random();
        int k, len, gap;
        logic [3:0] v;
        clear_obs();
        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 7);
            v = 4'($urandom_range(0, 15));
            len = $urandom_range(1, 9);
            gap = $urandom_range(0, 2);
            hold(8'd1 << k, ($urandom_range(0, 9) == 0) ? 7'h00 : pat_tab[v], len);
            idle(gap);
        end
        idle(10);
        checks++; if (o_pulses != m_pulses) begin errors++; $display("FAIL rand_pulses: got %0d want %0d", o_pulses, m_pulses); end
        checks++; if (frame_value !== m_value) begin errors++; $display("FAIL rand_value: got %h want %h", frame_value, m_value); end
        checks++; if (frame_blank !== m_blank) begin errors++; $display("FAIL rand_blank: got %h want %h", frame_blank, m_blank); end
        checks++; if (frame_count !== m_count) begin errors++; $display("FAIL rand_count: got %0d want %0d", frame_count, m_count); end
        checks++; if ({err_pattern, err_select} !== {m_errp, m_errs}) begin errors++; $display("FAIL rand_errs: got %b want %b", {err_pattern, err_select}, {m_errp, m_errs}); end
        if (m_pulses > 0) begin
            checks++; if (o_pub_cyc != m_pub_cyc) begin errors++; $display("FAIL rand_latency: got cycle %0d want %0d", o_pub_cyc, m_pub_cyc); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        v = $urandom;
        scan(v, 8'h00, 6, 1);
        for (int k = 0; k < 4; k++) hold(8'd1 << k, pat_tab[k], 6);
        rst = 1'b1;
        model_reset();
        step(8'd0, 7'd0, 1'b0);
        checks++; if (frame_value !== 32'd0) begin errors++; $display("FAIL rmid_value: got %h want 0", frame_value); end
        checks++; if (frame_blank !== 8'd0) begin errors++; $display("FAIL rmid_blank: got %h want 0", frame_blank); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", frame_valid); end
        checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL rmid_count: got %0d want 0", frame_count); end
        checks++; if ({err_pattern, err_select} !== 2'b00) begin errors++; $display("FAIL rmid_errs: got %b want 00", {err_pattern, err_select}); end
        step(8'd0, 7'd0, 1'b0);
        rst = 1'b0;
        clear_obs();
        v = $urandom;
        for (int k = 4; k < 8; k++) hold(8'd1 << k, pat_tab[k], 6);
        scan(v, 8'h00, 6, 1);
        idle(8);
        checks++; if (o_pulses != 1) begin errors++; $display("FAIL rmid_pulses: got %0d want 1", o_pulses); end
        checks++; if (frame_value !== v) begin errors++; $display("FAIL rmid_newvalue: got %h want %h", frame_value, v); end
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL rmid_newcount: got %0d want 1", frame_count); end
    endtask

    initial begin
        rst = 1'b1;
        DIGIT = 8'hFF;
        SEG = 7'h7F;
        err_clr = 1'b0;
        test_reset();
        test_basic_frame();
        test_start_mid();
        test_pattern_err();
        test_select_err();
        test_glitch_blank();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
